cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
Sits directly downstream of the CPU core's inst_sram/data_sram ports and merges the two request streams onto one single-port memory bus. The bus uses a req/addr_ok/data_ok handshake. The block holds one transaction outstanding at a time and returns per-port stall signals. The core feeds these into its stall controller, so each pipeline stage holds its request until the access completes.

Parameters:
ADDR_W, 32, address width of the CPU ports and the bus
DATA_W, 32, data width; byte strobe width is DATA_W/8

Ports:
clk  in  1  sole clock; all state updates on its rising edge
resetn  in  1  reset, synchronous, active-low
inst_en  in  1  instruction fetch request; read-only
inst_addr  in  ADDR_W  fetch address
inst_rdata  out  DATA_W  fetched word, registered
inst_stall  out  1  fetch not yet complete; CPU holds inst_en/inst_addr
data_en  in  1  load/store request
data_wen  in  DATA_W/8  byte write enables; 0 = load
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_rdata  out  DATA_W  load word, registered
data_stall  out  1  load/store not yet complete
bus_req  out  1  bus request valid
bus_wr  out  1  1 = write
bus_wstrb  out  DATA_W/8  byte strobes for a write
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  request accepted this cycle
bus_data_ok  in  1  read data valid / write complete this cycle
bus_rdata  in  DATA_W  bus read data

Behaviour:
- Reset: clk with resetn=0 forces the following, whatever transaction is in flight:
  - state IDLE; owner NONE;
  - bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata all 0;
  - inst_rdata and data_rdata both 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If data_en=1, latch data_addr/data_wen/data_wdata, set owner DATA, go to REQ. Data has fixed priority over inst.
  - Else if inst_en=1, latch inst_addr, set bus_wr=0 and wstrb=0, set owner INST, go to REQ.
  - Else stay in IDLE.
- REQ:
  - bus_req=1, driven from the latched registers, which stay stable until accepted.
  - bus_wr = |latched wen.
  - On bus_addr_ok=1: drop bus_req next cycle and go to WAIT. If bus_data_ok=1 in the same cycle, capture the data and go straight to DONE.
- WAIT:
  - On bus_data_ok=1 with owner INST: capture bus_rdata into inst_rdata, go to DONE.
  - On bus_data_ok=1 with owner DATA: capture bus_rdata into data_rdata only when the access is a read; writes leave data_rdata unchanged. Go to DONE.
- DONE: lasts exactly one cycle, then IDLE. Owner returns to NONE in IDLE.
- Stalls (combinational):
  - inst_stall = inst_en & ~(state==DONE & owner==INST)
  - data_stall = data_en & ~(state==DONE & owner==DATA)
  - A port with en=0 never stalls.
- Latency: 3 cycles minimum (IDLE→REQ→DONE) when addr_ok and data_ok arrive together in the first REQ cycle. Each wait cycle on the bus adds one cycle.
- Simultaneous requests:
  - The data access completes first; inst_stall stays high throughout, including the data DONE cycle.
  - The inst access starts at the following IDLE.
  - Inst starvation is allowed; the CPU freezes fetch while mem stalls.
- Stray or late handshakes:
  - bus_data_ok in IDLE, DONE or REQ (before addr_ok) is ignored.
  - bus_addr_ok outside REQ is ignored.
  - A late bus_data_ok after a mid-transaction reset is ignored.
- Request change: inst_en or data_en dropping while their transaction is in flight does not abort it. The transaction completes and its result is captured.
- rdata registers hold their value until the next read completion on the same port.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3);
  - owner encoding (NONE, INST, DATA);
  - the default ADDR_W and DATA_W.
- Single module, no sub-module; FSM and request latch together are under ~250 lines.

Test Plan:
- Inst read only:
  - Stimulus: inst_en=1, inst_addr=0x0000_0100, bus acks addr_ok+data_ok in the first REQ cycle with rdata=0x2402_0001.
  - Required: bus_req high 1 cycle, inst_stall low on the 3rd cycle, inst_rdata=0x2402_0001.
- Store:
  - Stimulus: data_en=1, data_wen=4'b0011, addr=0x0000_8004, wdata=0xDEAD_BEEF, addr_ok on 2nd REQ cycle, data_ok 2 cycles later.
  - Required: bus_wr=1, bus_wstrb=0011, bus signals stable until accepted, data_rdata unchanged, data_stall low for exactly 1 cycle.
- Both requests together:
  - Stimulus: inst_en=1 and data_en=1 (load, addr 0x10) in the same cycle.
  - Required: bus sees the data address 0x10 first and the inst address second; inst_stall stays high until the second DONE.
- Reset in WAIT:
  - Stimulus: resetn=0 for 1 clk while in WAIT, then data_ok=1 arrives after reset.
  - Required: state IDLE, all outputs 0, the late data_ok is ignored, no rdata update.
- Stray handshake:
  - Stimulus: bus_data_ok=1 in IDLE with rdata=0xFFFF_FFFF.
  - Required: inst_rdata and data_rdata unchanged, no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the CPU inst/data to single-bus arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Merges inst/data SRAM-style ports onto one req/addr_ok/data_ok bus, one
// transaction outstanding, data port has fixed priority.
module cpu_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_stall,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W/8-1:0] wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                capture;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    capture      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        owner_d = OWN_NONE;
        if (data_en) begin
          addr_d  = data_addr;
          wen_d   = data_wen;
          wdata_d = data_wdata;
          owner_d = OWN_DATA;
          state_d = ST_REQ;
        end else if (inst_en) begin
          addr_d  = inst_addr;
          wen_d   = '0;
          wdata_d = '0;
          owner_d = OWN_INST;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // data_ok only counts once the address has been accepted
        if (bus_addr_ok) begin
          capture = bus_data_ok;
          state_d = bus_data_ok ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (owner_q == OWN_INST)
        inst_rdata_d = bus_rdata;
      else if (owner_q == OWN_DATA && wen_q == '0)
        data_rdata_d = bus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      addr_q       <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_req    = (state_q == ST_REQ);
  assign bus_wr     = |wen_q;
  assign bus_wstrb  = wen_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  assign inst_stall = inst_en & ~(state_q == ST_DONE && owner_q == OWN_INST);
  assign data_stall = data_en & ~(state_q == ST_DONE && owner_q == OWN_DATA);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench: transaction-level arbiter/bus model with random CPU
// traffic, random bus latencies and stray handshakes.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_en, data_en;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_stall, data_stall;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  cpu_mem_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_stall(data_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // bus-side memory; untouched words read as an address-derived pattern
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // CPU-side requests, held until their completion cycle
  logic        i_pend = 0, d_pend = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_wen = 0;

  // arbiter reference: one transaction selected at cycle m_s, bus_req for
  // 1+m_a cycles, data_ok m_d cycles after acceptance, done the cycle after
  int          cyc = 0;
  logic        m_busy = 0, m_data = 0;
  int          m_s = 0, m_a = 0, m_d = 0;
  logic [31:0] exp_ird = 0, exp_drd = 0;

  int pi = 0, pd = 0, stray = 0, fa = -1, fd = -1;
  int req_cnt = 0, d_low_cnt = 0;
  logic [31:0] acc_q[$];

  task automatic step();
    int k, ac, dc, c;
    logic [31:0] cur_addr, drv;
    logic        cur_wr, exp_req;
    @(negedge clk);
    k = cyc;
    if (!i_pend && $urandom_range(99) < pi) begin
      i_pend = 1; i_addr = 32'h100 + ($urandom_range(15) << 2);
    end
    if (!d_pend && $urandom_range(99) < pd) begin
      d_pend  = 1;
      d_addr  = 32'h8000 + ($urandom_range(15) << 2);
      d_wen   = $urandom_range(1) ? 4'($urandom_range(15, 1)) : 4'h0;
      d_wdata = $urandom;
    end
    inst_en = i_pend; inst_addr = i_addr;
    data_en = d_pend; data_addr = d_addr; data_wen = d_wen; data_wdata = d_wdata;

    ac = m_s + 1 + m_a; dc = ac + m_d; c = dc + 1;
    cur_addr = m_data ? d_addr : i_addr;
    cur_wr   = m_data ? (d_wen != 0) : 1'b0;
    bus_addr_ok = m_busy && k == ac;
    bus_data_ok = m_busy && k == dc;
    bus_rdata   = $urandom;
    if (bus_data_ok && !cur_wr) bus_rdata = rd(cur_addr);
    if ($urandom_range(99) < stray) begin
      if (!m_busy || k < ac || k == c) bus_data_ok = 1;
      if (!m_busy || k > ac) bus_addr_ok = 1;
    end
    drv = bus_rdata;

    #1;
    exp_req = m_busy && k <= ac;
    chk("bus_req", bus_req, exp_req);
    if (exp_req) begin
      chk("bus_addr", bus_addr, cur_addr);
      chk("bus_wr", bus_wr, cur_wr);
      chk("bus_wstrb", bus_wstrb, m_data ? d_wen : 4'h0);
      if (m_data) chk("bus_wdata", bus_wdata, d_wdata);
    end
    if (m_busy && k == ac) acc_q.push_back(bus_addr);
    if (bus_req) req_cnt++;
    if (data_en && !data_stall) d_low_cnt++;
    chk("inst_stall", inst_stall, i_pend && !(m_busy && k == c && !m_data));
    chk("data_stall", data_stall, d_pend && !(m_busy && k == c && m_data));
    chk("inst_rdata", inst_rdata, exp_ird);
    chk("data_rdata", data_rdata, exp_drd);

    @(posedge clk);
    cyc++;
    if (m_busy && k == dc) begin
      if (!m_data) exp_ird = drv;
      else if (d_wen == 0) exp_drd = drv;
      else begin
        logic [31:0] w;
        w = rd(d_addr);
        for (int b = 0; b < 4; b++) if (d_wen[b]) w[8*b +: 8] = d_wdata[8*b +: 8];
        mem[d_addr] = w;
      end
    end
    if (m_busy && k == c) begin
      m_busy = 0;
      if (m_data) d_pend = 0; else i_pend = 0;
    end else if (!m_busy && (d_pend || i_pend)) begin
      m_busy = 1; m_data = d_pend; m_s = k;
      m_a = (fa >= 0) ? fa : int'($urandom_range(2));
      m_d = (fd >= 0) ? fd : int'($urandom_range(2));
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((i_pend || d_pend || m_busy) && n < 60) begin step(); n++; end
    if (n >= 60) chk({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    resetn = 0; inst_en = 0; data_en = 0; inst_addr = 0; data_addr = 0;
    data_wen = 0; data_wdata = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_wr", bus_wr, 0);
    chk("rst_bus_wstrb", bus_wstrb, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    resetn = 1;

    // single fetch, bus answers both handshakes in the first REQ cycle
    mem[32'h100] = 32'h2402_0001;
    fa = 0; fd = 0; req_cnt = 0;
    i_pend = 1; i_addr = 32'h100;
    drain("inst_read");
    step();
    chk("inst_read_rdata", inst_rdata, 32'h2402_0001);
    chk("inst_read_req_cycles", req_cnt, 1);

    // store with a slow bus
    fa = 1; fd = 2; d_low_cnt = 0;
    d_pend = 1; d_addr = 32'h8004; d_wen = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    drain("store");
    step();
    chk("store_data_rdata", data_rdata, 0);
    chk("store_stall_low_cycles", d_low_cnt, 1);
    chk("store_mem_low", mem[32'h8004] & 32'h0000_FFFF, 32'h0000_BEEF);

    // simultaneous requests: data first
    fa = -1; fd = -1; acc_q.delete();
    i_pend = 1; i_addr = 32'h104;
    d_pend = 1; d_addr = 32'h10; d_wen = 0; d_wdata = 0;
    drain("both");
    chk("both_count", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("both_first", acc_q[0], 32'h10);
      chk("both_second", acc_q[1], 32'h104);
    end

    // stray handshakes while idle
    stray = 100;
    repeat (4) step();
    stray = 0;

    // reset while in WAIT, then a late data_ok
    fa = 0; fd = 5;
    d_pend = 1; d_addr = 32'h8010; d_wen = 0;
    begin
      int n = 0;
      while (!(m_busy && cyc > m_s + 1 + m_a) && n < 20) begin step(); n++; end
      if (n >= 20) chk("rst_wait_timeout", 1, 0);
    end
    @(negedge clk);
    resetn = 0; inst_en = 0; data_en = 0; bus_addr_ok = 0; bus_data_ok = 0;
    @(posedge clk);
    @(negedge clk);
    chk("wrst_bus_req", bus_req, 0);
    chk("wrst_bus_wr", bus_wr, 0);
    chk("wrst_bus_addr", bus_addr, 0);
    chk("wrst_bus_wstrb", bus_wstrb, 0);
    chk("wrst_bus_wdata", bus_wdata, 0);
    chk("wrst_inst_rdata", inst_rdata, 0);
    chk("wrst_data_rdata", data_rdata, 0);
    resetn = 1; bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    chk("late_ok_data_rdata", data_rdata, 0);
    chk("late_ok_bus_req", bus_req, 0);
    chk("late_ok_data_stall", data_stall, 0);
    m_busy = 0; d_pend = 0; i_pend = 0; exp_ird = 0; exp_drd = 0; cyc += 2;
    fa = -1; fd = -1;

    // random traffic
    pi = 30; pd = 30; stray = 15;
    repeat (3000) step();
    pi = 0; pd = 0; stray = 0;
    drain("random");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
